// File: rtl/sd_rejoin_pkg.sv
// Default configuration shared by the sd_rejoin slice.
package sd_rejoin_pkg;

    localparam int unsigned MirrorDefault = 2;
    localparam int unsigned WidthDefault  = 32;
    localparam int unsigned TmoWDefault   = 8;

endpackage

// File: rtl/sd_rejoin_lane.sv
// One rejoin lane: capture flag, data hold register and lane ready.
`include "sdlib_defines.svh"

module sd_rejoin_lane #(
    parameter int unsigned width = sd_rejoin_pkg::WidthDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             got,
    output logic [width-1:0] hold
);

    logic got_q, got_d;
    logic cap;

    assign c_drdy = ~got_q;
    assign cap    = c_srdy & ~got_q;
    assign got    = got_q;

    always_comb begin
        got_d = got_q;
        if (clr) begin
            got_d = 1'b0;
        end else if (cap) begin
            got_d = 1'b1;
        end
    end

    always_ff @(`SDLIB_CLOCKING) begin
        if (reset) begin
            got_q <= `SDLIB_DELAY 1'b0;
        end else begin
            got_q <= `SDLIB_DELAY got_d;
        end
    end

    // Data path is deliberately unreset; got qualifies it.
    always_ff @(posedge clk) begin
        if (cap) begin
            hold <= `SDLIB_DELAY c_data;
        end
    end

endmodule

// File: rtl/sdlib_defines.svh
// Shared sdlib clocking and delay macros.
// SDLIB_DELAY stays empty for synthesis.
`ifndef SDLIB_DEFINES_SVH
`define SDLIB_DEFINES_SVH

`define SDLIB_CLOCKING posedge clk or posedge reset
`define SDLIB_DELAY

`endif

// File: rtl/sd_rejoin.sv
// Rejoins mirrored srdy/drdy fork branches into one beat per expect token.
// Optional timeout detector enabled by defining SD_REJOIN_TIMEOUT_EN.
`include "sdlib_defines.svh"

module sd_rejoin
    import sd_rejoin_pkg::*;
#(
    parameter int unsigned mirror = MirrorDefault,
    parameter int unsigned width  = WidthDefault
`ifdef SD_REJOIN_TIMEOUT_EN
    ,
    parameter int unsigned tmo_w  = TmoWDefault
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    e_srdy,
    output logic                    e_drdy,
    input  logic [mirror-1:0]       e_mask,
    input  logic [mirror-1:0]       c_srdy,
    output logic [mirror-1:0]       c_drdy,
    input  logic [mirror*width-1:0] c_data,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [mirror*width-1:0] p_data,
    output logic [mirror-1:0]       p_vld
`ifdef SD_REJOIN_TIMEOUT_EN
    ,
    output logic                    err_tmo
`endif
);

    logic              exp_vld_q, exp_vld_d;
    logic [mirror-1:0] exp_mask_q, exp_mask_d;
    logic [mirror-1:0] got;
    logic [mirror-1:0] clr;
    logic              xfer;

    assign e_drdy = ~exp_vld_q;
    assign p_srdy = exp_vld_q & ((got & exp_mask_q) == exp_mask_q);
    assign xfer   = p_srdy & p_drdy;
    assign clr    = xfer ? exp_mask_q : '0;
    assign p_vld  = p_srdy ? exp_mask_q : '0;

    always_comb begin
        exp_vld_d  = exp_vld_q;
        exp_mask_d = exp_mask_q;
        if (xfer) begin
            exp_vld_d = 1'b0;
        end else if (e_srdy & ~exp_vld_q) begin
            exp_vld_d  = 1'b1;
            // An all-zero mask means every lane contributes.
            exp_mask_d = (e_mask == '0) ? '1 : e_mask;
        end
    end

    always_ff @(`SDLIB_CLOCKING) begin
        if (reset) begin
            exp_vld_q  <= `SDLIB_DELAY 1'b0;
            exp_mask_q <= `SDLIB_DELAY '0;
        end else begin
            exp_vld_q  <= `SDLIB_DELAY exp_vld_d;
            exp_mask_q <= `SDLIB_DELAY exp_mask_d;
        end
    end

    for (genvar i = 0; i < mirror; i++) begin : g_lane
        logic [width-1:0] hold;

        sd_rejoin_lane #(
            .width (width)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr[i]),
            .c_srdy (c_srdy[i]),
            .c_drdy (c_drdy[i]),
            .c_data (c_data[i*width +: width]),
            .got    (got[i]),
            .hold   (hold)
        );

        assign p_data[i*width +: width] = exp_mask_q[i] ? hold : '0;
    end

`ifdef SD_REJOIN_TIMEOUT_EN
    logic [tmo_w-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_tmo_q, err_tmo_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_tmo_d = 1'b0;
        if (~exp_vld_q | p_srdy) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // Pulse only on the step into saturation.
            err_tmo_d = (tmo_cnt_d == '1);
        end
    end

    always_ff @(`SDLIB_CLOCKING) begin
        if (reset) begin
            tmo_cnt_q <= `SDLIB_DELAY '0;
            err_tmo_q <= `SDLIB_DELAY 1'b0;
        end else begin
            tmo_cnt_q <= `SDLIB_DELAY tmo_cnt_d;
            err_tmo_q <= `SDLIB_DELAY err_tmo_d;
        end
    end

    assign err_tmo = err_tmo_q;
`endif

endmodule

// File: tb/tb_sd_rejoin.sv
// Directed bench for sd_rejoin with a scoreboard of expected output beats.
module tb_sd_rejoin;

    localparam int unsigned Mirror = 2;
    localparam int unsigned Width  = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    e_srdy = 1'b0;
    logic                    e_drdy;
    logic [Mirror-1:0]       e_mask = '0;
    logic [Mirror-1:0]       c_srdy = '0;
    logic [Mirror-1:0]       c_drdy;
    logic [Mirror*Width-1:0] c_data = '0;
    logic                    p_srdy;
    logic                    p_drdy = 1'b1;
    logic [Mirror*Width-1:0] p_data;
    logic [Mirror-1:0]       p_vld;
`ifdef SD_REJOIN_TIMEOUT_EN
    logic                    err_tmo;
`endif

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    logic [Mirror*Width+Mirror-1:0] sb_q[$];

    always #5 clk = ~clk;

    sd_rejoin #(
        .mirror (Mirror),
        .width  (Width)
`ifdef SD_REJOIN_TIMEOUT_EN
        ,
        .tmo_w  (4)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .e_srdy (e_srdy),
        .e_drdy (e_drdy),
        .e_mask (e_mask),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .p_srdy (p_srdy),
        .p_drdy (p_drdy),
        .p_data (p_data),
        .p_vld  (p_vld)
`ifdef SD_REJOIN_TIMEOUT_EN
        ,
        .err_tmo (err_tmo)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] data, input logic [1:0] vld);
        sb_q.push_back({data, vld});
    endtask

    // Scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && p_srdy && p_drdy) begin
            xfers++;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $error("FAIL sb_extra: got %0h expected no beat", {p_data, p_vld});
            end else begin
                logic [17:0] exp_beat;
                exp_beat = sb_q.pop_front();
                assert ({p_data, p_vld} === exp_beat) else begin
                    fails++;
                    $error("FAIL sb_beat: got %0h expected %0h", {p_data, p_vld}, exp_beat);
                end
            end
        end
    end

    initial begin
        int x0;
`ifdef SD_REJOIN_TIMEOUT_EN
        int pulses;
        int pulse_at;
`endif
        #2;
        check("rst_p_srdy", 32'(p_srdy), 32'd0);
        check("rst_e_drdy", 32'(e_drdy), 32'd1);
        check("rst_c_drdy", 32'(c_drdy), 32'h3);
        check("rst_p_vld", 32'(p_vld), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // 1: all-lanes token, lanes at different times.
        push(16'h3CA5, 2'b11);
        e_srdy = 1'b1; e_mask = 2'b00;
        tick();
        e_srdy = 1'b0;
        tick(); tick();
        c_srdy = 2'b01; c_data = 16'h00A5;
        tick();
        c_srdy = 2'b00;
        tick(); tick();
        check("t1_wait", 32'(p_srdy), 32'd0);
        c_srdy = 2'b10; c_data = 16'h3C00;
        tick();
        c_srdy = 2'b00;
        check("t1_rise", 32'(p_srdy), 32'd1);
        tick();
        check("t1_drop", 32'(p_srdy), 32'd0);
        check("t1_e_drdy", 32'(e_drdy), 32'd1);
        check("t1_xfers", 32'(xfers), 32'd1);

        // 2: early unexpected lane held for a later token.
        c_srdy = 2'b10; c_data = 16'h7700;
        tick();
        c_srdy = 2'b00;
        check("t2_held", 32'(c_drdy), 32'h1);
        push(16'h0011, 2'b01);
        e_srdy = 1'b1; e_mask = 2'b01;
        tick();
        e_srdy = 1'b0;
        c_srdy = 2'b01; c_data = 16'h0011;
        tick();
        c_srdy = 2'b00;
        tick();
        check("t2_l1_stall", 32'(c_drdy), 32'h1);
        push(16'h7700, 2'b10);
        e_srdy = 1'b1; e_mask = 2'b10;
        tick();
        e_srdy = 1'b0;
        check("t2_immediate", 32'(p_srdy), 32'd1);
        tick();
        check("t2_c_drdy", 32'(c_drdy), 32'h3);
        check("t2_xfers", 32'(xfers), 32'd3);

        // 3: backpressure holds the result stable.
        p_drdy = 1'b0;
        push(16'hBBAA, 2'b11);
        e_srdy = 1'b1; e_mask = 2'b11;
        c_srdy = 2'b11; c_data = 16'hBBAA;
        tick();
        e_srdy = 1'b0; c_srdy = 2'b00; c_data = 16'h0000;
        x0 = xfers;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_p_srdy", 32'(p_srdy), 32'd1);
            check("t3_p_data", 32'(p_data), 32'hBBAA);
            check("t3_e_drdy", 32'(e_drdy), 32'd0);
            check("t3_c_drdy", 32'(c_drdy), 32'h0);
        end
        p_drdy = 1'b1;
        tick();
        check("t3_one_xfer", 32'(xfers - x0), 32'd1);
        check("t3_e_drdy_after", 32'(e_drdy), 32'd1);

        // 4: lane data well ahead of its token.
        c_srdy = 2'b01; c_data = 16'h005A;
        tick();
        c_srdy = 2'b00;
        tick(); tick();
        check("t4_no_token", 32'(p_srdy), 32'd0);
        push(16'h005A, 2'b01);
        e_srdy = 1'b1; e_mask = 2'b01;
        tick();
        e_srdy = 1'b0;
        check("t4_rise", 32'(p_srdy), 32'd1);
        check("t4_p_vld", 32'(p_vld), 32'h1);
        tick();

        // 5: reset mid-item discards partial state.
        e_srdy = 1'b1; e_mask = 2'b11;
        tick();
        e_srdy = 1'b0;
        c_srdy = 2'b01; c_data = 16'h0099;
        tick();
        c_srdy = 2'b00;
        check("t5_partial", 32'(c_drdy), 32'h2);
        reset = 1'b1;
        #1;
        check("t5_rst_p_srdy", 32'(p_srdy), 32'd0);
        check("t5_rst_e_drdy", 32'(e_drdy), 32'd1);
        check("t5_rst_c_drdy", 32'(c_drdy), 32'h3);
        tick();
        reset = 1'b0;
        push(16'h2211, 2'b11);
        e_srdy = 1'b1; e_mask = 2'b11;
        c_srdy = 2'b11; c_data = 16'h2211;
        tick();
        e_srdy = 1'b0; c_srdy = 2'b00;
        check("t5_fresh", 32'(p_srdy), 32'd1);
        tick();

`ifdef SD_REJOIN_TIMEOUT_EN
        // 6: missing lane trips the timeout once, then completes.
        e_srdy = 1'b1; e_mask = 2'b11;
        c_srdy = 2'b01; c_data = 16'h0044;
        tick();
        e_srdy = 1'b0; c_srdy = 2'b00;
        pulses = 0;
        pulse_at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (err_tmo) begin
                pulses++;
                pulse_at = k;
            end
        end
        check("t6_pulses", 32'(pulses), 32'd1);
        check("t6_pulse_at", 32'(pulse_at), 32'd15);
        push(16'h5544, 2'b11);
        c_srdy = 2'b10; c_data = 16'h5500;
        tick();
        c_srdy = 2'b00;
        check("t6_done", 32'(p_srdy), 32'd1);
        tick();
        check("t6_no_err", 32'(err_tmo), 32'd0);
`endif

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sd_rejoin.md
Name: sd_rejoin

Overview:
- Rejoins the N mirrored branches of an srdy/drdy fork back into one stream. This is the receiving end of a mirrored fork.
- Each branch delivers its result independently, at any time.
- An expect channel carries a lane mask naming which branches contribute to the current item.
- When every expected lane has been captured, the block emits one output beat with all lane data concatenated. Lanes not in the mask read as zero.

Parameters:
- mirror, 2, number of rejoined lanes (>=1)
- width, 32, data width per lane
- tmo_w, 8, timeout counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- e_srdy  in  1  expect token valid
- e_drdy  out  1  expect token accepted
- e_mask  in  mirror  expected lanes; all-zero means all lanes
- c_srdy  in  mirror  per-lane data valid
- c_drdy  out  mirror  per-lane data accepted
- c_data  in  mirror*width  lane i occupies bits [i*width +: width]
- p_srdy  out  1  joined result valid
- p_drdy  in  1  joined result accepted
- p_data  out  mirror*width  joined data, same lane packing as c_data
- p_vld  out  mirror  effective mask of the emitted result

Interface decision: reset is reset, asynchronous, active-high; clock is clk.

Behaviour:
- State:
  - exp_vld: 1 bit.
  - exp_mask: mirror bits, stored as the effective mask (zero is expanded to all-ones at capture).
  - got[i]: one flag per lane.
  - hold[i]: width-bit data register per lane.
  - Reset clears exp_vld, exp_mask and got. hold is not reset.
- Expect channel:
  - e_drdy = ~exp_vld.
  - On e_srdy & e_drdy: exp_vld <= 1, exp_mask <= effective mask.
  - Only one token is outstanding at a time.
- Lane i:
  - c_drdy[i] = ~got[i].
  - On c_srdy[i] & c_drdy[i]: hold[i] <= lane data, got[i] <= 1.
  - Lanes accept independently of exp_vld. A lane may arrive before its expect token.
- Completion:
  - p_srdy = exp_vld & ((got & exp_mask) == exp_mask).
  - Decoded purely from flops, so no combinational path from any input to p_srdy.
  - Latency: p_srdy rises the cycle after the last required lane or the token is accepted, whichever is later.
- Output data:
  - p_data lane i = hold[i] if exp_mask[i], else 0.
  - p_vld = exp_mask when p_srdy is high, else 0.
  - p_data and p_vld are stable while p_srdy=1 and p_drdy=0.
- Output transfer (p_srdy & p_drdy):
  - exp_vld <= 0.
  - got <= got & ~exp_mask.
- Unexpected lanes:
  - A lane outside exp_mask keeps got set and holds its data for a later token.
  - That lane stalls (c_drdy=0) until consumed.
- Simultaneous events:
  - A lane cannot be captured in the same cycle its flag clears, since c_drdy[i]=0 while got[i]=1.
  - A new token is accepted no earlier than the cycle after the transfer.
  - Sustained throughput is therefore one result per 2 cycles; this is acceptable.
- Reset mid-operation: all partial captures and the pending token are discarded. p_srdy drops immediately (async).
- Nonblocking assigns use `SDLIB_DELAY; flops use `SDLIB_CLOCKING.

Optional Feature:
- Macro: SD_REJOIN_TIMEOUT_EN.
- When defined:
  - Adds output port err_tmo (1 bit) and a tmo_w-bit counter.
  - The counter clears when exp_vld=0 or p_srdy=1, and increments each cycle while exp_vld=1 and p_srdy=0.
  - On reaching all-ones, err_tmo pulses high for one cycle and the counter saturates until cleared.
  - Data flow is unaffected.
- When undefined: no port, no counter, no logic.

Decomposition:
- Shared sdlib defines header holds `SDLIB_CLOCKING and `SDLIB_DELAY. No other shared constants.
- Sub-module sd_rejoin_lane:
  - Contains the got flag, hold register and c_drdy for one lane.
  - Inputs: clr (transfer & mask bit), c_srdy, c_data.
  - Instantiated mirror times by generate.

Test Plan:
1. mirror=2, width=8: token e_mask=0; lane0 sends 0xA5 at cycle 3, lane1 sends 0x3C at cycle 6, p_drdy=1 -> p_srdy rises cycle 7, p_data=0x3CA5, p_vld=2'b11, single beat.
2. Token e_mask=2'b01, lane0 sends 0x11 -> output p_data=0x0011, p_vld=01. Lane1 sent 0x77 earlier -> stays held, c_drdy[1]=0. Next token mask=10 -> immediate output 0x7700 one cycle after token accept.
3. Lanes complete with p_drdy=0 for 5 cycles -> p_srdy held high, p_data stable, e_drdy=0, c_drdy=00. Release -> exactly one transfer, then e_drdy=1.
4. Lane data arrives 3 cycles before its token -> p_srdy asserts the cycle after token accept.
5. Assert reset while lane0 is captured and the token is pending -> p_srdy=0, got=0, e_drdy=1; a fresh item then completes correctly.
6. With SD_REJOIN_TIMEOUT_EN, tmo_w=4: token accepted, lane1 never arrives -> err_tmo pulses once, 15 cycles after accept; arrival of lane1 clears the counter and the output proceeds.
